// File: rtl/branch_cond_eval.sv
// branch_cond_eval: four-phase branch condition evaluator with SCC interlock and optional stats.
// Define BRANCH_STATS_EN to build the saturating taken/not-taken counters.
module branch_cond_eval #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int STATS_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [3:0]             Flags,
  input  logic                   SCC,
  input  logic                   Req,
  input  logic [3:0]             Cond,
  output logic                   Ack,
  output logic                   Taken,
  output logic                   Busy,
  output logic [STATS_WIDTH-1:0] TakenCount,
  output logic [STATS_WIDTH-1:0] NotTakenCount
);
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, HOLD} state_t;
  state_t state;
  logic [3:0] cond_q;
  logic n, z, v, c, lt, base, hit;
  if (DATAWIDTH_BUS < 1) begin : g_bad_width
    $error("DATAWIDTH_BUS must be positive");
  end
  assign Busy = state != IDLE;
  // Cond[3] inverts the base predicate selected by Cond[2:0].
  always_comb begin
    {n, z, v, c} = Flags;
    lt = n ^ v;
    base = cond_q[2:0] == 3'd0 ? 1'b0 :
           cond_q[2:0] == 3'd1 ? z :
           cond_q[2:0] == 3'd2 ? z | lt :
           cond_q[2:0] == 3'd3 ? lt :
           cond_q[2:0] == 3'd4 ? c | z :
           cond_q[2:0] == 3'd5 ? c :
           cond_q[2:0] == 3'd6 ? n : v;
    hit = base ^ cond_q[3];
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      Ack <= 1'b0;
      Taken <= 1'b0;
      cond_q <= 4'd0;
    end else begin
      case (state)
        IDLE: if (Req) begin
          cond_q <= Cond;
          state <= SCC ? WAIT : EVAL;
        end
        WAIT: state <= !Req ? IDLE : SCC ? WAIT : EVAL;
        EVAL: if (!Req) state <= IDLE;
        else begin
          Taken <= hit;
          Ack <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (!Req) begin
          Ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TakenCount <= '0;
      NotTakenCount <= '0;
    end else if (state == EVAL && Req) begin
      if (hit && !(&TakenCount)) TakenCount <= TakenCount + STATS_WIDTH'(1);
      if (!hit && !(&NotTakenCount)) NotTakenCount <= NotTakenCount + STATS_WIDTH'(1);
    end
  end
`else
  assign TakenCount = '0;
  assign NotTakenCount = '0;
`endif
endmodule

// File: tb/tb_branch_cond_eval.sv
// tb_branch_cond_eval: directed + randomized bench for branch_cond_eval against a condition-table model.
module tb_branch_cond_eval;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;
  logic CLK = 0, RESET = 1, SCC = 0, Req = 0;
  logic [3:0] Flags = 0, Cond = 0;
  logic Ack, Taken, Busy;
  logic [SW-1:0] TakenCount, NotTakenCount;
  int checks = 0, errors = 0, exp_tk = 0, exp_nt = 0;
  logic exp_taken = 0;

  branch_cond_eval #(.DATAWIDTH_BUS(32), .STATS_WIDTH(SW)) dut (
    .CLK(CLK), .RESET(RESET), .Flags(Flags), .SCC(SCC), .Req(Req), .Cond(Cond),
    .Ack(Ack), .Taken(Taken), .Busy(Busy),
    .TakenCount(TakenCount), .NotTakenCount(NotTakenCount)
  );

  always #5 CLK = ~CLK;

  function automatic bit ref_taken(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cf;
    {n, z, v, cf} = f;
    case (c)
      4'd0:  return 0;
      4'd1:  return z;
      4'd2:  return z | (n ^ v);
      4'd3:  return n ^ v;
      4'd4:  return cf | z;
      4'd5:  return cf;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1;
      4'd9:  return !z;
      4'd10: return !(z | (n ^ v));
      4'd11: return !(n ^ v);
      4'd12: return !(cf | z);
      4'd13: return !cf;
      4'd14: return !n;
      default: return !v;
    endcase
  endfunction

  function automatic int ecnt(input int v);
`ifdef BRANCH_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts;
    check("taken_count", 32'(TakenCount), ecnt(exp_tk));
    check("not_taken_count", 32'(NotTakenCount), ecnt(exp_nt));
  endtask

  // Full handshake; flags are scrambled until just before the EVAL edge, Cond after acceptance.
  task automatic eval(input logic [3:0] c, input logic [3:0] f, input int nscc);
    bit t;
    t = ref_taken(c, f);
    Req = 1; Cond = c; SCC = (nscc > 0); Flags = 4'($urandom);
    for (int i = 0; i < nscc; i++) begin
      step;
      check("wait_ack", 32'(Ack), 0);
      SCC = (i + 1 < nscc);
      Cond = 4'($urandom);
    end
    step;
    check("pre_ack", 32'(Ack), 0);
    check("busy", 32'(Busy), 1);
    Flags = f; Cond = 4'($urandom);
    step;
    check("ack", 32'(Ack), 1);
    check($sformatf("taken c=%b f=%b", c, f), 32'(Taken), 32'(t));
    if (t) exp_tk = exp_tk < SAT ? exp_tk + 1 : SAT;
    else exp_nt = exp_nt < SAT ? exp_nt + 1 : SAT;
    exp_taken = t;
    check_counts;
    Req = 0; Flags = 4'($urandom);
    step;
    check("ack_drop", 32'(Ack), 0);
    check("idle_busy", 32'(Busy), 0);
    check("taken_hold", 32'(Taken), 32'(t));
  endtask

  initial begin
    step; step;
    check("rst_ack", 32'(Ack), 0);
    check("rst_taken", 32'(Taken), 0);
    check("rst_busy", 32'(Busy), 0);
    check_counts;
    RESET = 0;
    step;
    check("post_rst_ack", 32'(Ack), 0);
    eval(4'b0001, 4'b0100, 0);
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) eval(4'(c), 4'(f), 0);
    eval(4'b0001, 4'b0100, 3);
    eval(4'b1000, 4'($urandom), 0);
    repeat (40) eval(4'($urandom), 4'($urandom), int'($urandom_range(0, 4)));
    // Abort from WAIT
    Req = 1; SCC = 1; Cond = 4'($urandom);
    step;
    check("wait_busy", 32'(Busy), 1);
    Req = 0;
    step;
    check("abort_wait_ack", 32'(Ack), 0);
    check("abort_wait_busy", 32'(Busy), 0);
    check("abort_wait_taken", 32'(Taken), 32'(exp_taken));
    check_counts;
    // Abort from EVAL
    SCC = 0; Req = 1; Cond = 4'($urandom);
    step;
    Req = 0;
    step;
    check("abort_eval_ack", 32'(Ack), 0);
    check("abort_eval_busy", 32'(Busy), 0);
    check("abort_eval_taken", 32'(Taken), 32'(exp_taken));
    check_counts;
    // Reset while in EVAL
    Req = 1; Cond = 4'b1000;
    step;
    check("eval_busy", 32'(Busy), 1);
    #2 RESET = 1;
    #1;
    check("mid_rst_ack", 32'(Ack), 0);
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_taken", 32'(Taken), 0);
    exp_tk = 0; exp_nt = 0; exp_taken = 0;
    check_counts;
    Req = 0;
    step;
    RESET = 0;
    step;
    check("post_mid_rst_ack", 32'(Ack), 0);
    check("post_mid_rst_busy", 32'(Busy), 0);
    repeat (17) eval(4'b1000, 4'($urandom), 0);
    check("sat_taken", 32'(TakenCount), ecnt(SAT));
    check("sat_not_taken", 32'(NotTakenCount), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
